// File: rtl/uart_cmd_parser.sv
// Framed command decoder between UART RX and TX.
// Parses SYNC/CMD/LEN/payload/CHK frames, holds one frame, replies ACK/NAK.
module uart_cmd_parser #(
  parameter int          MAX_LEN        = 16,
  parameter int          TIMEOUT_CYCLES = 104160,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  localparam int         LW = $clog2(MAX_LEN + 1),
  localparam int         AW = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic          cmd_valid,
  output logic [7:0]    cmd_code,
  output logic [LW-1:0] cmd_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          cmd_ack,
  output logic [7:0]    err_count,
  output logic          reply_drop
);

  localparam int         TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK
  } state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_gap;
  logic [7:0]    r_chk, r_code_in;
  logic [LW-1:0] r_len, r_idx;
  logic          r_supp;
  logic [7:0]    r_buf [MAX_LEN];
  logic          r_cmd_valid;
  logic [7:0]    r_cmd_code;
  logic [LW-1:0] r_cmd_len;
  logic [7:0]    r_err;
  logic          r_pend, r_drop, r_tx_start;
  logic [7:0]    r_reply, r_tx_data;

  logic w_tout, w_nak, w_acc, w_wr, w_busy, w_last;
  logic w_rep, w_issue;

  assign w_busy  = r_cmd_valid & ~cmd_ack;
  assign w_last  = (r_idx + 1'b1) == r_len;
  assign w_tout  = (r_state != S_IDLE) && !rx_ready &&
                   (r_gap == TW'(TIMEOUT_CYCLES - 1));
  assign w_rep   = w_nak | w_acc;
  assign w_issue = r_pend & ~tx_busy & ~r_tx_start;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_nak  = 1'b0;
    w_acc  = 1'b0;
    w_wr   = 1'b0;
    if (w_tout) begin
      w_next = S_IDLE;
    end else if (rx_ready) begin
      unique case (r_state)
        S_IDLE: if (rx_data == SYNC_BYTE) w_next = S_CMD;
        S_CMD:  w_next = S_LEN;
        S_LEN: begin
          if (rx_data > MAX_B) begin
            w_nak  = 1'b1;
            w_next = S_IDLE;
          end else if (rx_data == 8'h00) begin
            w_next = S_CHK;
          end else begin
            w_next = S_PAY;
          end
        end
        S_PAY: begin
          w_wr = ~r_cmd_valid;
          if (w_last) w_next = S_CHK;
        end
        S_CHK: begin
          w_next = S_IDLE;
          // a suppressed payload write means the buffer no longer matches
          if (rx_data != r_chk || w_busy || r_supp) w_nak = 1'b1;
          else                                      w_acc = 1'b1;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_idx[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gap       <= '0;
      r_chk       <= '0;
      r_code_in   <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_supp      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= '0;
      r_cmd_len   <= '0;
      r_err       <= '0;
      r_pend      <= 1'b0;
      r_drop      <= 1'b0;
      r_reply     <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      if (rx_ready || r_state == S_IDLE || w_tout) r_gap <= '0;
      else                                         r_gap <= r_gap + 1'b1;

      if (rx_ready) begin
        unique case (r_state)
          S_CMD: begin
            r_code_in <= rx_data;
            r_chk     <= rx_data;
          end
          S_LEN: begin
            r_chk  <= r_chk ^ rx_data;
            r_len  <= rx_data[LW-1:0];
            r_idx  <= '0;
            r_supp <= 1'b0;
          end
          S_PAY: begin
            r_chk <= r_chk ^ rx_data;
            r_idx <= r_idx + 1'b1;
            if (r_cmd_valid) r_supp <= 1'b1;
          end
          default: ;
        endcase
      end

      if (w_acc) begin
        r_cmd_valid <= 1'b1;
        r_cmd_code  <= r_code_in;
        r_cmd_len   <= r_len;
      end else if (cmd_ack) begin
        r_cmd_valid <= 1'b0;
      end

      if ((w_nak || w_tout) && r_err != 8'hFF) r_err <= r_err + 1'b1;

      r_tx_start <= w_issue;
      if (w_issue) r_tx_data <= r_reply;

      if (w_rep) begin
        if (r_pend && !w_issue) begin
          r_drop <= 1'b1;
        end else begin
          r_pend  <= 1'b1;
          r_reply <= w_acc ? ACK_BYTE : NAK_BYTE;
        end
      end else if (w_issue) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_code   = r_cmd_code;
  assign cmd_len    = r_cmd_len;
  assign err_count  = r_err;
  assign reply_drop = r_drop;
  assign rd_data    = r_cmd_valid ? r_buf[rd_addr] : 8'h00;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames plus random frames
// checked against a frame-level reference model.
module tb_uart_cmd_parser;

  localparam int ML = 16;
  localparam int TO = 40;
  localparam int LW = 5;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready = 1'b0;
  logic          tx_busy = 1'b0;
  logic          cmd_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          cmd_valid;
  logic [7:0]    cmd_code;
  logic [LW-1:0] cmd_len;
  logic [7:0]    rd_data;
  logic [7:0]    err_count;
  logic          reply_drop;

  uart_cmd_parser #(.MAX_LEN(ML), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_len(cmd_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .cmd_ack(cmd_ack),
    .err_count(err_count), .reply_drop(reply_drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int gap_fix = -1;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] q[$];

  bit         m_valid;
  logic [7:0] m_code;
  int         m_len;
  logic [7:0] m_buf [ML];
  int         m_err;

  always @(negedge clk) if (tx_start) obs_q.push_back(tx_data);

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(logic [7:0] b, bit ack);
    rx_data  = b;
    rx_ready = 1'b1;
    cmd_ack  = ack;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    cmd_ack  = 1'b0;
  endtask

  task automatic model(bit ack_last);
    int i;
    int len;
    logic [7:0] x;
    bit busy;
    bit supp;
    i = 0;
    while (i < q.size() && q[i] != 8'hA5) i++;
    if (i + 2 >= q.size()) return;
    len = int'(q[i+2]);
    if (len > ML) begin
      exp_q.push_back(8'h15);
      m_err++;
      return;
    end
    x = q[i+1] ^ q[i+2];
    for (int k = 0; k < len; k++) x ^= q[i+3+k];
    busy = m_valid && !ack_last;
    supp = m_valid && len > 0;
    if (x != q[i+3+len] || busy || supp) begin
      exp_q.push_back(8'h15);
      m_err++;
      if (ack_last) m_valid = 0;
    end else begin
      exp_q.push_back(8'h06);
      m_valid = 1;
      m_code  = q[i+1];
      m_len   = len;
      for (int k = 0; k < len; k++) m_buf[k] = q[i+3+k];
    end
  endtask

  task automatic send_list(bit ack_last);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i], ack_last && i == q.size() - 1);
      if (i != q.size() - 1)
        idle(gap_fix >= 0 ? gap_fix : $urandom_range(1, 3));
    end
    model(ack_last);
  endtask

  task automatic check_replies(string tag);
    int n;
    check({tag, "_nrep"}, obs_q.size(), exp_q.size());
    n = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_rep"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_state(string tag);
    check({tag, "_valid"}, cmd_valid, m_valid);
    check({tag, "_err"}, err_count, m_err);
    if (m_valid) begin
      check({tag, "_code"}, cmd_code, m_code);
      check({tag, "_len"}, cmd_len, m_len);
      for (int i = 0; i < m_len; i++) begin
        rd_addr = AW'(i);
        @(negedge clk);
        check({tag, "_rd"}, rd_data, m_buf[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack();
    cmd_ack = 1'b1;
    @(posedge clk);
    #1;
    cmd_ack = 1'b0;
    m_valid = 0;
    check("ack_clear", cmd_valid, 1'b0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_txs"}, tx_start, 1'b0);
    check({tag, "_txd"}, tx_data, 8'h00);
    check({tag, "_valid"}, cmd_valid, 1'b0);
    check({tag, "_code"}, cmd_code, 8'h00);
    check({tag, "_len"}, cmd_len, 0);
    check({tag, "_err"}, err_count, 8'h00);
    check({tag, "_drop"}, reply_drop, 1'b0);
    check({tag, "_rd"}, rd_data, 8'h00);
  endtask

  int kind;
  int len;
  logic [7:0] b;
  logic [7:0] x;

  initial begin
    m_valid = 0;
    m_err   = 0;
    m_len   = 0;
    m_code  = '0;
    idle(3);
    check_zero("reset");
    rst = 1'b1;
    idle(2);

    q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_list(0);
    idle(4);
    check_replies("good");
    check_state("good");
    do_ack();

    q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
    send_list(0);
    idle(4);
    check_replies("badchk");
    check_state("badchk");

    q = '{8'h00, 8'hFF, 8'hA5, 8'h33, 8'h11};
    send_list(0);
    idle(4);
    check_replies("oversize");
    check_state("oversize");

    q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_list(0);
    idle(4);
    check_replies("hold");
    q = '{8'hA5, 8'h20, 8'h00, 8'h20};
    send_list(0);
    idle(4);
    check_replies("busybuf");
    check_state("busybuf");

    q = '{8'hA5, 8'h30, 8'h00, 8'h30};
    send_list(1);
    idle(4);
    check_replies("simack");
    check_state("simack");
    do_ack();

    send_byte(8'hA5, 0);
    idle(2);
    send_byte(8'h10, 0);
    idle(TO);
    m_err++;
    idle(4);
    check_replies("timeout");
    check_state("timeout");
    q = '{8'hA5, 8'h44, 8'h01, 8'h5A, 8'h1F};
    send_list(0);
    idle(4);
    check_replies("post_to");
    check_state("post_to");
    do_ack();

    gap_fix = TO - 1;
    q = '{8'hA5, 8'h40, 8'h00, 8'h40};
    send_list(0);
    gap_fix = -1;
    idle(4);
    check_replies("to_edge");
    check_state("to_edge");
    do_ack();

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      q.delete();
      if ($urandom_range(0, 2) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        q.push_back(b);
      end
      q.push_back(8'hA5);
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      if (kind == 0) begin
        q.push_back(8'($urandom_range(ML + 1, 255)));
      end else begin
        len = $urandom_range(0, ML);
        q.push_back(8'(len));
        x = b ^ 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          q.push_back(b);
          x ^= b;
        end
        if (kind < 3) x ^= 8'(1 << $urandom_range(0, 7));
        q.push_back(x);
      end
      send_list(0);
      idle(4);
      check_replies("rand");
      check_state("rand");
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    if (m_valid) do_ack();
    tx_busy = 1'b1;
    q = '{8'hA5, 8'h01, 8'h00, 8'h01};
    send_list(0);
    idle(2);
    q = '{8'hA5, 8'h02, 8'h00, 8'h02};
    send_list(0);
    void'(exp_q.pop_back());
    idle(10);
    check("bp_hold", obs_q.size(), 0);
    check("bp_drop", reply_drop, 1'b1);
    tx_busy = 1'b0;
    idle(5);
    check_replies("bp");
    check_state("bp");
    check("bp_drop2", reply_drop, 1'b1);

    send_byte(8'hA5, 0);
    idle(1);
    send_byte(8'h10, 0);
    rst = 1'b0;
    idle(2);
    check_zero("midrst");
    rst = 1'b1;
    idle(TO + 5);
    check("midrst_txs", obs_q.size(), 0);
    check("midrst_err", err_count, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
